// File: rtl/val2_shift_sequencer.sv
// Iterative second-operand shifter for the EXE stage: decodes one shift request per handshake,
// shifts at most STEP bits per cycle and holds val_2/shift_c until the consumer takes them.
module val2_shift_sequencer #(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rm,
    input  logic [11:0] shift_operand,
    input  logic        imm,
    input  logic        mem_en,
    input  logic        c_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] val_2,
    output logic        shift_c,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_t      state;
    shift_op_t   op;
    logic [31:0] work_val;
    logic        work_c;
    logic [4:0]  rem;

    logic        accept;
    logic [31:0] dec_val;
    shift_op_t   dec_op;
    logic [4:0]  dec_amt;

    logic [4:0]  step_amt;
    logic [4:0]  lsl_idx;
    logic [4:0]  rsh_idx;
    logic [31:0] step_val;
    logic        step_c;

    assign in_ready = ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign busy     = (state != IDLE);

    // Offset form wins over immediate form; both leave the register operand unused.
    always_comb begin
        dec_val = rm;
        dec_op  = shift_op_t'(shift_operand[6:5]);
        dec_amt = shift_operand[11:7];
        if (mem_en) begin
            dec_val = {20'd0, shift_operand};
            dec_op  = OP_LSL;
            dec_amt = '0;
        end else if (imm) begin
            dec_val = {24'd0, shift_operand[7:0]};
            dec_op  = OP_ROR;
            dec_amt = {shift_operand[11:8], 1'b0};
        end
    end

    // lsl_idx wraps to 32-s modulo 32; only meaningful while s is 1..STEP.
    always_comb begin
        step_amt = (rem < STEP_AMT) ? rem : STEP_AMT;
        lsl_idx  = 5'd0 - step_amt;
        rsh_idx  = step_amt - 5'd1;
        step_val = work_val;
        step_c   = work_c;
        case (op)
            OP_LSL: begin
                step_val = work_val << step_amt;
                step_c   = work_val[lsl_idx];
            end
            OP_LSR: begin
                step_val = work_val >> step_amt;
                step_c   = work_val[rsh_idx];
            end
            OP_ASR: begin
                step_val = 32'($signed(work_val) >>> step_amt);
                step_c   = work_val[rsh_idx];
            end
            OP_ROR: begin
                step_val = (work_val >> step_amt) | (work_val << (6'd32 - {1'b0, step_amt}));
                step_c   = work_val[rsh_idx];
            end
            default: begin
                step_val = work_val;
                step_c   = work_c;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= OP_LSL;
            work_val  <= '0;
            work_c    <= 1'b0;
            rem       <= '0;
            out_valid <= 1'b0;
            val_2     <= '0;
            shift_c   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else if (accept) begin
            // Covers both IDLE and the DONE-handshake edge, so back-to-back skips IDLE.
            work_val <= dec_val;
            op       <= dec_op;
            rem      <= dec_amt;
            work_c   <= c_in;
            if (dec_amt == 5'd0) begin
                state     <= DONE;
                out_valid <= 1'b1;
                val_2     <= dec_val;
                shift_c   <= c_in;
            end else begin
                state     <= SHIFT;
                out_valid <= 1'b0;
            end
        end else begin
            case (state)
                SHIFT: begin
                    work_val <= step_val;
                    work_c   <= step_c;
                    rem      <= rem - step_amt;
                    if (rem == step_amt) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        val_2     <= step_val;
                        shift_c   <= step_c;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Randomised bench for val2_shift_sequencer: each request is compared against a whole-shift
// arithmetic model for value, carry, latency and output hold behaviour.
module tb_val2_shift_sequencer;

    localparam int STEP = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rm;
    logic [11:0] shift_operand;
    logic        imm;
    logic        mem_en;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] val_2;
    logic        shift_c;
    logic        busy;

    int          passed;
    int          total;
    logic [31:0] last_v;
    logic        last_c;

    val2_shift_sequencer #(.STEP(STEP)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rm            (rm),
        .shift_operand (shift_operand),
        .imm           (imm),
        .mem_en        (mem_en),
        .c_in          (c_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .val_2         (val_2),
        .shift_c       (shift_c),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

    // Whole shift computed in one go from the instruction rules.
    function automatic void ref_model(input logic [31:0] r, input logic [11:0] so,
                                      input logic im, input logic me, input logic ci,
                                      output logic [31:0] v, output logic c, output int a);
        logic [31:0] b;
        int          sel;
        if (me) begin
            v = {20'd0, so};
            c = ci;
            a = 0;
            return;
        end
        if (im) begin
            b   = {24'd0, so[7:0]};
            sel = 3;
            a   = 2 * int'(so[11:8]);
        end else begin
            b   = r;
            sel = int'(so[6:5]);
            a   = int'(so[11:7]);
        end
        v = b;
        c = ci;
        if (a == 0) return;
        case (sel)
            0: begin v = b << a; c = b[32 - a]; end
            1: begin v = b >> a; c = b[a - 1]; end
            2: begin v = 32'($signed(b) >>> a); c = b[a - 1]; end
            default: begin v = (b >> a) | (b << (32 - a)); c = v[31]; end
        endcase
    endfunction

    // Issues one request; from_done means the previous result is consumed on this accept edge.
    task automatic run_transaction(input logic [31:0] t_rm, input logic [11:0] t_so,
                                   input logic t_imm, input logic t_mem, input logic t_cin,
                                   input int hold, input bit leave_done, input bit from_done);
        logic [31:0] exp_v;
        logic        exp_c;
        int          amt;
        int          lat;
        int          k;
        ref_model(t_rm, t_so, t_imm, t_mem, t_cin, exp_v, exp_c, amt);
        lat = (amt + STEP - 1) / STEP;
        rm = t_rm; shift_operand = t_so; imm = t_imm; mem_en = t_mem; c_in = t_cin;
        in_valid = 1'b1;
        out_ready = from_done;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        rm = $urandom; shift_operand = 12'($urandom); imm = 1'($urandom); mem_en = 1'($urandom);
        c_in = 1'($urandom);
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            total++;
            if (val_2 !== last_v || shift_c !== last_c || busy !== 1'b1)
                $display("FAIL shift_hold: val_2=%h c=%b busy=%b required val_2=%h c=%b busy=1",
                         val_2, shift_c, busy, last_v, last_c);
            else passed++;
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (k !== lat) $display("FAIL latency: edges=%0d required %0d (A=%0d)", k, lat, amt);
        else passed++;
        total++;
        if (val_2 !== exp_v || shift_c !== exp_c || busy !== 1'b1)
            $display("FAIL result: val_2=%h c=%b busy=%b required val_2=%h c=%b busy=1 (rm=%h so=%h imm=%b mem=%b)",
                     val_2, shift_c, busy, exp_v, exp_c, t_rm, t_so, t_imm, t_mem);
        else passed++;
        last_v = exp_v;
        last_c = exp_c;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || val_2 !== exp_v || shift_c !== exp_c || in_ready !== 1'b0)
                $display("FAIL done_hold: out_valid=%b val_2=%h c=%b in_ready=%b required 1 %h %b 0",
                         out_valid, val_2, shift_c, in_ready, exp_v, exp_c);
            else passed++;
        end
        if (!leave_done) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || val_2 !== exp_v || shift_c !== exp_c)
                $display("FAIL release: out_valid=%b busy=%b val_2=%h c=%b required 0 0 %h %b",
                         out_valid, busy, val_2, shift_c, exp_v, exp_c);
            else passed++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rm = '0; shift_operand = '0; imm = 1'b0; mem_en = 1'b0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || val_2 !== 32'd0 || shift_c !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_state: out_valid=%b val_2=%h c=%b busy=%b required 0 0 0 0",
                     out_valid, val_2, shift_c, busy);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        else passed++;
        last_v = '0;
        last_c = 1'b0;
    endtask

    task automatic test_directed;
        run_transaction(32'h1234_5678, 12'hABC, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        total++;
        if (last_v !== 32'h0000_0ABC || last_c !== 1'b1)
            $display("FAIL model_mem: model=%h %b required 00000abc 1", last_v, last_c);
        else passed++;
        run_transaction(32'hDEAD_BEEF, 12'h4FF, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        run_transaction(32'h8000_0001, 12'h080, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        run_transaction(32'h8000_0000, 12'hFC0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        run_transaction(32'hF0F0_1234, 12'hFE0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_transaction(32'h0000_00C3, 12'h03A, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        run_transaction(32'h0000_0000, 12'hF01, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_transaction(32'h0F00_00F0, 12'h222, 1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b0);
        run_transaction(32'hA5A5_5A5A, 12'h6E0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        run_transaction(32'h0000_1234, 12'h000, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1);
        run_transaction(32'h1111_2222, 12'h2A7, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_flush;
        // Flush during SHIFT of ROR #20 while a new request waits.
        rm = 32'h1357_9BDF; shift_operand = 12'hA60; imm = 1'b0; mem_en = 1'b0; c_in = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        rm = 32'hFFFF_0000; shift_operand = 12'h123;
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL shift_not_ready: in_ready=%b busy=%b required 0 1", in_ready, busy);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
        else passed++;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || val_2 !== last_v || shift_c !== last_c)
            $display("FAIL flush_shift: out_valid=%b busy=%b val_2=%h c=%b required 0 0 %h %b",
                     out_valid, busy, val_2, shift_c, last_v, last_c);
        else passed++;
        run_transaction(32'h1357_9BDF, 12'hA60, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);

        // Flush in DONE beats both the output handshake and a new accept.
        run_transaction(32'h8765_4321, 12'h1C4, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        rm = 32'hCAFE_F00D; shift_operand = 12'h000;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL flush_done: out_valid=%b busy=%b required 0 0", out_valid, busy);
        else passed++;

        // Asynchronous reset in the middle of a shift.
        rm = 32'h0246_8ACE; shift_operand = 12'hA60; imm = 1'b0; mem_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || val_2 !== 32'd0 || shift_c !== 1'b0)
            $display("FAIL reset_midshift: out_valid=%b busy=%b val_2=%h c=%b required 0 0 0 0",
                     out_valid, busy, val_2, shift_c);
        else passed++;
        last_v = '0;
        last_c = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_transaction(32'h0246_8ACE, 12'hA60, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        bit prev_ld;
        bit ld;
        prev_ld = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ld = (i < 79) && ($urandom_range(1, 0) == 1);
            run_transaction($urandom, 12'($urandom), 1'($urandom), ($urandom_range(3, 0) == 0),
                            1'($urandom), int'($urandom_range(2, 0)), ld, prev_ld);
            prev_ld = ld;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset;
        test_directed;
        test_back_to_back;
        test_flush;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
